// File: rtl/uart_tx_fifo_drain_if.sv
// FIFO read-side bundle between the TX buffer FIFO (first-word-fall-through) and the UART drain.
// The master is the drain that pops words; the slave is the FIFO that presents its head word.
interface uart_tx_fifo_drain_if #(
  parameter int unsigned DBIT = 8
);
  logic            fifo_empty;
  logic [DBIT-1:0] fifo_data;
  logic            fifo_rd;

  modport master (input fifo_empty, input fifo_data, output fifo_rd);
  modport slave  (output fifo_empty, output fifo_data, input fifo_rd);
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// Pops words from the TX FIFO and serializes them as start/data/[parity]/stop UART frames,
// paced by a 16x-oversampling baud tick.
module uart_tx_fifo_drain #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16,
  parameter bit          PAR_EN  = 1'b0,
  parameter bit          PAR_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tick,
  uart_tx_fifo_drain_if.master fifo,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done_tick
);

  localparam int unsigned TICK_MAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int unsigned TW       = $clog2(TICK_MAX);
  localparam int unsigned BW       = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [TW-1:0] BIT_LAST  = TW'(15);
  localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DBIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t          state_q, state_n;
  logic [TW-1:0]   tick_q, tick_n;
  logic [BW-1:0]   bit_q, bit_n;
  logic [DBIT-1:0] shreg_q, shreg_n;
  logic            par_q, par_n;
  logic            tx_q, tx_n;
  logic            busy_q;
  logic            pop_c;
  logic            done_c;

  // State and datapath registers; tx follows the line level of the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      tick_q  <= tick_n;
      bit_q   <= bit_n;
      shreg_q <= shreg_n;
      par_q   <= par_n;
      tx_q    <= tx_n;
      busy_q  <= (state_n != IDLE);
    end
  end

  // Next-state, counters and the line value for the upcoming cycle.
  always_comb begin
    state_n = state_q;
    tick_n  = tick_q;
    bit_n   = bit_q;
    shreg_n = shreg_q;
    par_n   = par_q;
    pop_c   = 1'b0;
    done_c  = 1'b0;
    tx_n    = 1'b1;

    case (state_q)
      IDLE: begin
        if (!fifo.fifo_empty) begin
          pop_c   = 1'b1;
          shreg_n = DBIT'(fifo.fifo_data);
          par_n   = (^fifo.fifo_data) ^ PAR_ODD;
          tick_n  = '0;
          state_n = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_q == BIT_LAST) begin
            tick_n  = '0;
            bit_n   = '0;
            state_n = DATA;
          end else begin
            tick_n = tick_q + TW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick_q == BIT_LAST) begin
            tick_n  = '0;
            shreg_n = shreg_q >> 1;
            if (bit_q == DATA_LAST) begin
              state_n = PAR_EN ? PARITY : STOP;
            end else begin
              bit_n = bit_q + BW'(1);
            end
          end else begin
            tick_n = tick_q + TW'(1);
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (tick_q == BIT_LAST) begin
            tick_n  = '0;
            state_n = STOP;
          end else begin
            tick_n = tick_q + TW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (tick_q == STOP_LAST) begin
            tick_n  = '0;
            done_c  = 1'b1;
            state_n = IDLE;
          end else begin
            tick_n = tick_q + TW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

  // The pop strobe is held off while reset is asserted so no word is lost in reset.
  assign fifo.fifo_rd  = pop_c & reset;
  assign tx            = tx_q;
  assign tx_busy       = busy_q;
  assign tx_done_tick  = done_c;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain: frames are captured tick by tick and compared
// against hand-computed bit patterns for several parameter sets.
`timescale 1ns/1ps
module tb_uart_tx_fifo_drain;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 16x tick every 4 clk, plus an always-on tick for the fast instance
  logic [1:0] tdiv = 2'd0;
  always @(posedge clk) tdiv <= tdiv + 2'd1;
  logic tick4;
  logic tick_all;
  assign tick4    = (tdiv == 2'd3);
  assign tick_all = 1'b1;

  uart_tx_fifo_drain_if #(.DBIT(8)) f0 ();
  uart_tx_fifo_drain_if #(.DBIT(8)) fpe ();
  uart_tx_fifo_drain_if #(.DBIT(8)) fpo ();
  uart_tx_fifo_drain_if #(.DBIT(8)) fsb ();

  logic tx0, busy0, done0;
  logic tx_pe, busy_pe, done_pe;
  logic tx_po, busy_po, done_po;
  logic tx_sb, busy_sb, done_sb;

  uart_tx_fifo_drain #(.DBIT(8), .SB_TICK(16), .PAR_EN(1'b0), .PAR_ODD(1'b0)) dut (
    .clk(clk), .reset(reset), .s_tick(tick4), .fifo(f0.master),
    .tx(tx0), .tx_busy(busy0), .tx_done_tick(done0));

  uart_tx_fifo_drain #(.DBIT(8), .SB_TICK(16), .PAR_EN(1'b1), .PAR_ODD(1'b0)) dut_pe (
    .clk(clk), .reset(reset), .s_tick(tick4), .fifo(fpe.master),
    .tx(tx_pe), .tx_busy(busy_pe), .tx_done_tick(done_pe));

  uart_tx_fifo_drain #(.DBIT(8), .SB_TICK(16), .PAR_EN(1'b1), .PAR_ODD(1'b1)) dut_po (
    .clk(clk), .reset(reset), .s_tick(tick4), .fifo(fpo.master),
    .tx(tx_po), .tx_busy(busy_po), .tx_done_tick(done_po));

  uart_tx_fifo_drain #(.DBIT(8), .SB_TICK(32), .PAR_EN(1'b0), .PAR_ODD(1'b0)) dut_sb (
    .clk(clk), .reset(reset), .s_tick(tick_all), .fifo(fsb.master),
    .tx(tx_sb), .tx_busy(busy_sb), .tx_done_tick(done_sb));

  // Main FIFO model: initial block owns the write pointer, the pop process owns the read pointer
  logic [7:0] fq_mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign f0.fifo_empty = (rd_ptr == wr_ptr);
  assign f0.fifo_data  = fq_mem[rd_ptr[5:0]];
  always @(posedge clk) if (f0.fifo_rd && (rd_ptr != wr_ptr)) rd_ptr <= rd_ptr + 1;

  int req_pe = 0, ack_pe = 0, req_po = 0, ack_po = 0, req_sb = 0, ack_sb = 0;
  assign fpe.fifo_empty = (req_pe == ack_pe);
  assign fpo.fifo_empty = (req_po == ack_po);
  assign fsb.fifo_empty = (req_sb == ack_sb);
  assign fpe.fifo_data  = 8'h07;
  assign fpo.fifo_data  = 8'h07;
  assign fsb.fifo_data  = 8'h00;
  always @(posedge clk) begin
    if (fpe.fifo_rd && (req_pe != ack_pe)) ack_pe <= ack_pe + 1;
    if (fpo.fifo_rd && (req_po != ack_po)) ack_po <= ack_po + 1;
    if (fsb.fifo_rd && (req_sb != ack_sb)) ack_sb <= ack_sb + 1;
  end

  int rd_cnt = 0, done_cnt = 0, bad_rd = 0;
  always @(posedge clk) begin
    if (f0.fifo_rd) rd_cnt <= rd_cnt + 1;
    if (done0) done_cnt <= done_cnt + 1;
    if ((f0.fifo_rd && f0.fifo_empty) || (fpe.fifo_rd && fpe.fifo_empty) ||
        (fpo.fifo_rd && fpo.fifo_empty) || (fsb.fifo_rd && fsb.fifo_empty))
      bad_rd <= bad_rd + 1;
  end

  int   sel = 0;
  logic obs_tx, obs_tick, obs_done;
  always_comb begin
    case (sel)
      1:       begin obs_tx = tx_pe; obs_tick = tick4;    obs_done = done_pe; end
      2:       begin obs_tx = tx_po; obs_tick = tick4;    obs_done = done_po; end
      3:       begin obs_tx = tx_sb; obs_tick = tick_all; obs_done = done_sb; end
      default: begin obs_tx = tx0;   obs_tick = tick4;    obs_done = done0;   end
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fq_mem[wr_ptr[5:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  // Capture one frame of the selected instance: tx sampled on every tick, grouped 16 ticks per bit.
  task automatic capture(output logic [15:0] bits, output int nticks, output int nclk,
                         output int nbad, output int nwait);
    int idx;
    bits = '0; nticks = 0; nclk = 0; nbad = 0; nwait = 0;
    @(negedge clk);
    while ((obs_tx !== 1'b0) && (nwait < 5000)) begin
      @(negedge clk);
      nwait++;
    end
    while (nclk < 5000) begin
      nclk++;
      if (obs_tick) begin
        idx = nticks / 16;
        if (idx < 16) begin
          if ((nticks % 16) == 0) bits[idx] = obs_tx;
          else if (bits[idx] !== obs_tx) nbad++;
        end
        nticks++;
      end
      if (obs_done === 1'b1) break;
      @(negedge clk);
    end
  endtask

  logic [15:0] bits;
  int nt, nc, nb, nw, rd0, d0, viol, k;
  logic [7:0] words [0:2];

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx",   32'(tx0),        32'd1);
    check("rst_busy", 32'(busy0),      32'd0);
    check("rst_rd",   32'(f0.fifo_rd), 32'd0);
    check("rst_done", 32'(done0),      32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // T1: single 0xA5 frame
    rd0 = rd_cnt; d0 = done_cnt;
    push(8'hA5);
    capture(bits, nt, nc, nb, nw);
    check("t1_bits",   32'(bits), 32'h34A);
    check("t1_ticks",  nt, 160);
    check("t1_levels", nb, 0);
    @(negedge clk);
    check("t1_busy_after", 32'(busy0), 32'd0);
    check("t1_tx_after",   32'(tx0),   32'd1);
    check("t1_rd_pulses",  rd_cnt - rd0,   1);
    check("t1_done_pulses", done_cnt - d0, 1);

    // T2: three preloaded words sent back to back
    repeat (4) @(negedge clk);
    rd0 = rd_cnt; d0 = done_cnt;
    words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF;
    for (int i = 0; i < 3; i++) push(words[i]);
    for (int i = 0; i < 3; i++) begin
      capture(bits, nt, nc, nb, nw);
      check("t2_start_wait", nw, 0);
      check("t2_bits", 32'(bits), 32'({1'b1, words[i], 1'b0}));
      check("t2_levels", nb, 0);
      if (i < 2) begin
        @(negedge clk);
        check("t2_gap_idle", 32'(busy0),      32'd0);
        check("t2_gap_pop",  32'(f0.fifo_rd), 32'd1);
        check("t2_gap_tx",   32'(tx0),        32'd1);
      end
    end
    @(negedge clk);
    check("t2_rd_pulses",   rd_cnt - rd0,   3);
    check("t2_done_pulses", done_cnt - d0,  3);

    // T3: empty FIFO with ticks running
    viol = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (f0.fifo_rd !== 1'b0 || tx0 !== 1'b1 || busy0 !== 1'b0) viol++;
    end
    check("t3_idle_quiet", viol, 0);

    // T4: async reset in the middle of data bit 3 of 0x3C
    rd0 = rd_cnt;
    push(8'h3C);
    nw = 0;
    @(negedge clk);
    while ((tx0 !== 1'b0) && (nw < 5000)) begin @(negedge clk); nw++; end
    k = 0;
    while ((k < 72) && (nw < 10000)) begin
      if (tick4) k++;
      @(negedge clk);
      nw++;
    end
    check("t4_pre_busy", 32'(busy0), 32'd1);
    check("t4_pre_bit3", 32'(tx0),   32'd1);
    push(8'h5A);
    #2 reset = 1'b0;
    #1;
    check("t4_rst_tx",   32'(tx0),        32'd1);
    check("t4_rst_busy", 32'(busy0),      32'd0);
    check("t4_rst_rd",   32'(f0.fifo_rd), 32'd0);
    repeat (3) @(negedge clk);
    check("t4_rst_hold_rd", 32'(f0.fifo_rd), 32'd0);
    reset = 1'b1;
    capture(bits, nt, nc, nb, nw);
    check("t4_bits",  32'(bits), 32'h2B4);
    check("t4_ticks", nt, 160);
    @(negedge clk);
    check("t4_rd_pulses", rd_cnt - rd0, 2);
    check("t4_fifo_empty", 32'(f0.fifo_empty), 32'd1);

    // T5: even then odd parity on 0x07
    sel = 1;
    req_pe = req_pe + 1;
    capture(bits, nt, nc, nb, nw);
    check("t5_even_bits",  32'(bits), 32'h60E);
    check("t5_even_ticks", nt, 176);
    @(negedge clk);
    check("t5_even_busy_after", 32'(busy_pe), 32'd0);
    sel = 2;
    req_po = req_po + 1;
    capture(bits, nt, nc, nb, nw);
    check("t5_odd_bits",  32'(bits), 32'h40E);
    check("t5_odd_ticks", nt, 176);
    @(negedge clk);
    check("t5_odd_busy_after", 32'(busy_po), 32'd0);

    // T6: tick every clk, two stop bits
    sel = 3;
    req_sb = req_sb + 1;
    capture(bits, nt, nc, nb, nw);
    check("t6_clks",  nc, 176);
    check("t6_ticks", nt, 176);
    check("t6_bits",  32'(bits), 32'h600);
    @(negedge clk);
    check("t6_busy_after", 32'(busy_sb), 32'd0);

    check("rd_while_empty", bad_rd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
